// File: rtl/rf_2p_banked.sv
// rtl/rf_2p_banked.sv - parametrised multi-bank 2-port register file with masked writes and clear sweep
module rf_2p_banked #(
  parameter int WORDS      = 12,
  parameter int DWD        = 16,
  parameter int BANKS      = 2,
  parameter int AWD        = $clog2(WORDS),
  parameter int BWD        = (BANKS > 1) ? $clog2(BANKS) : 1,
  parameter bit RD_PIPE    = 1'b0,
  parameter bit CLR_ON_RST = 1'b1
) (
  input  logic           i_clk,
  input  logic           i_rstn,
  input  logic           i_clear,
  output logic           o_ready,
  input  logic           i_read,
  input  logic [BWD-1:0] i_rbank,
  input  logic [AWD-1:0] i_raddr,
  output logic [DWD-1:0] o_rdata,
  output logic           o_rvalid,
  input  logic           i_write,
  input  logic [BWD-1:0] i_wbank,
  input  logic [AWD-1:0] i_waddr,
  input  logic [DWD-1:0] i_wdata,
  input  logic [DWD-1:0] i_wmask
);

  typedef enum logic {IDLE, CLEAR} state_t;

  logic [DWD-1:0] mem [BANKS][WORDS];

  state_t         state;
  logic [AWD-1:0] clr_addr;
  logic           clr_pend;
  logic           ready;

  logic           w_in, r_in, w_ok, r_ok;
  logic [DWD-1:0] w_merge;
  logic [DWD-1:0] r_word;

  logic           s1_valid;
  logic [DWD-1:0] s1_data;

  assign o_ready = ready;

  // Extra top bit keeps the compare correct when WORDS or BANKS is a power of two.
  assign w_in = ({1'b0, i_waddr} < (AWD+1)'(WORDS)) && ({1'b0, i_wbank} < (BWD+1)'(BANKS));
  assign r_in = ({1'b0, i_raddr} < (AWD+1)'(WORDS)) && ({1'b0, i_rbank} < (BWD+1)'(BANKS));
  assign w_ok = ready & i_write & w_in;
  assign r_ok = ready & i_read;

  always_comb begin
    w_merge = '0;
    r_word  = '0;
    if (w_in) begin
      w_merge = (mem[i_wbank][i_waddr] & ~i_wmask) | (i_wdata & i_wmask);
    end
    if (r_in) begin
      if (w_ok && (i_wbank == i_rbank) && (i_waddr == i_raddr)) begin
        r_word = w_merge;
      end else begin
        r_word = mem[i_rbank][i_raddr];
      end
    end
  end

  // clr_pend carries the post-reset sweep request into the first edge after release.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state    <= IDLE;
      clr_addr <= '0;
      clr_pend <= CLR_ON_RST;
      ready    <= ~CLR_ON_RST;
    end else begin
      case (state)
        IDLE: begin
          if (clr_pend || (ready && i_clear)) begin
            state    <= CLEAR;
            clr_addr <= '0;
            clr_pend <= 1'b0;
            ready    <= 1'b0;
          end
        end
        CLEAR: begin
          if (clr_addr == AWD'(WORDS - 1)) begin
            state <= IDLE;
            ready <= 1'b1;
          end else begin
            clr_addr <= clr_addr + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          ready <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (state == CLEAR) begin
      for (int b = 0; b < BANKS; b++) begin
        mem[b][clr_addr] <= '0;
      end
    end else if (w_ok) begin
      mem[i_wbank][i_waddr] <= w_merge;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      o_rvalid <= 1'b0;
      o_rdata  <= '0;
    end else begin
      s1_valid <= r_ok;
      if (r_ok) begin
        s1_data <= r_word;
      end
      if (RD_PIPE) begin
        o_rvalid <= s1_valid;
        if (s1_valid) begin
          o_rdata <= s1_data;
        end
      end else begin
        o_rvalid <= r_ok;
        if (r_ok) begin
          o_rdata <= r_word;
        end
      end
    end
  end

endmodule
